interface_o: RTL and testbench
==============================

Name: interface_o

Overview:
- Store-side counterpart of the peripheral read-data mux. Decodes CPU store cycles and either forwards the write to data memory or captures it into peripheral-facing registers.
- Buffers MP3 data words in a small FIFO toward the MP3 decoder driver.
- Issues SD commands through a valid/ready handshake.
- Stalls the CPU when a target cannot accept a store.

Parameters:
- FIFO_DEPTH, 8, MP3 FIFO entries (power of two).
- FIFO_AW, 3, log2(FIFO_DEPTH); pointer width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ADDR  input  32  CPU store address.
- DATA_W  input  32  CPU store data.
- WE  input  1  CPU store strobe, one cycle per accepted store.
- DMEM_WE  output  1  write enable to data memory.
- STALL  output  1  CPU must hold ADDR/DATA_W/WE and retry next cycle.
- VOL_REG  output  32  volume control register.
- LED_REG  output  32  LED/indicator register.
- MP3_DATA  output  32  FIFO head word.
- MP3_VALID  output  1  FIFO non-empty.
- MP3_READY  input  1  consumer accepts head word.
- SD_CMD  output  32  latched SD command word.
- SD_CMD_VALID  output  1  command pending.
- SD_CMD_READY  input  1  SD controller accepts command.
- STATUS  output  32  status word for read mux at 0x84C.

Behaviour:
- Peripheral space is ADDR[11]==1. Decode uses ADDR[11:0]:
  - 0x804 VOL_REG
  - 0x80C LED_REG
  - 0x840 MP3 FIFO push
  - 0x844 SD command
  - 0x848 control; DATA_W[0]=1 flushes the FIFO.
- Any other address, including unmatched 0x8xx: DMEM_WE = WE, combinational. Decoded hits: DMEM_WE = 0.
- STALL is combinational: (WE & hit 0x840 & full) | (WE & hit 0x844 & sd_pend).
  - A stalled store has no side effect. DMEM_WE = 0 during the stall.
- Store hit without stall: the target updates on the next rising edge. VOL_REG and LED_REG take all 32 bits.
- Reset values: VOL_REG, LED_REG, SD_CMD = 0; SD_CMD_VALID = 0; FIFO empty with pointers and count = 0.
  - MP3_VALID = 0. MP3_DATA is don't-care while MP3_VALID = 0. STATUS reflects the reset state.
- MP3 FIFO:
  - push = WE & hit 0x840 & !full; pop = MP3_VALID & MP3_READY.
  - Count is FIFO_AW+1 bits; pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full blocks push even if a pop occurs that cycle, so STALL depends on full only.
  - MP3_DATA = mem[rd_ptr], valid the same cycle MP3_VALID rises. Push-to-MP3_VALID latency is 1 cycle.
- Flush (store to 0x848 with bit0 = 1):
  - Pointers and count clear on the next edge.
  - A concurrent pop is discarded. A concurrent push cannot occur (single store per cycle).
- SD FSM, states IDLE and PEND:
  - IDLE + store to 0x844: SD_CMD <= DATA_W, SD_CMD_VALID <= 1, go PEND.
  - PEND: SD_CMD and SD_CMD_VALID held stable.
  - PEND + SD_CMD_READY: go IDLE; SD_CMD_VALID = 0 next cycle. SD_CMD retains its value.
  - Store to 0x844 in PEND stalls and is accepted on the first cycle after returning to IDLE.
  - SD_CMD_READY while IDLE is ignored.
- Reset asserted mid-operation clears the FSM and FIFO immediately. Pending data is lost.

Optional Feature:
- Macro IFACE_O_STATUS_EN.
- Defined: STATUS = {22'b0, count[FIFO_AW:0] zero-extended into bits [9:2]... } is superseded by this exact layout:
  - bit0 fifo_empty
  - bit1 fifo_full
  - bit2 sd_pend
  - bits[15:8] FIFO count, zero-extended
  - all other bits 0.
- Not defined: STATUS is constant 0, with no status logic instantiated.

Test Plan:
- Reset then store 0x804 data 0x0000_1F1F, then 0x123 data 0xAA → VOL_REG = 0x1F1F next cycle with DMEM_WE = 0; second store gives DMEM_WE = 1 and VOL_REG unchanged.
- Push 8 words 0..7 to 0x840 with MP3_READY = 0, then a 9th (0x99) → STALL = 1 on the 9th and STATUS full bit = 1. Raise MP3_READY → words 0..7 emerge in order, 0x99 accepted the cycle after the first pop, and 0x99 emerges last.
- FIFO holding 3 words, push + pop in the same cycle → count stays 3 and order is preserved.
- Store 0x844 data 0xCAFE0001 with SD_CMD_READY = 0 for 4 cycles, plus a second store 0x844 data 0x2 → SD_CMD_VALID = 1 with SD_CMD = 0xCAFE0001 stable; STALL = 1 for the second store. READY pulse → second command latched the following cycle.
- FIFO holding 5 words, store 0x848 data 1 with MP3_READY = 1 → MP3_VALID = 0 next cycle and count = 0.
- Assert RST_N low mid-SD-PEND with the FIFO non-empty → SD_CMD_VALID = 0 and MP3_VALID = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/interface_o.sv
// Store-side peripheral decoder: VOL/LED registers, MP3 word FIFO, SD command handshake.
// Define IFACE_O_STATUS_EN to drive the STATUS word; otherwise STATUS is tied to zero.
module interface_o #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_W,
  input  logic        WE,
  output logic        DMEM_WE,
  output logic        STALL,
  output logic [31:0] VOL_REG,
  output logic [31:0] LED_REG,
  output logic [31:0] MP3_DATA,
  output logic        MP3_VALID,
  input  logic        MP3_READY,
  output logic [31:0] SD_CMD,
  output logic        SD_CMD_VALID,
  input  logic        SD_CMD_READY,
  output logic [31:0] STATUS
);

  localparam logic [11:0] AddrVol = 12'h804;
  localparam logic [11:0] AddrLed = 12'h80C;
  localparam logic [11:0] AddrMp3 = 12'h840;
  localparam logic [11:0] AddrSd  = 12'h844;
  localparam logic [11:0] AddrCtl = 12'h848;

  localparam logic [FIFO_AW:0]   DepthCnt = FIFO_DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   CntOne   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PtrOne   = {{(FIFO_AW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StPend} sd_state_e;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic hit_vol, hit_led, hit_mp3, hit_sd, hit_ctl, hit_any;

  assign hit_vol = (ADDR[11:0] == AddrVol);
  assign hit_led = (ADDR[11:0] == AddrLed);
  assign hit_mp3 = (ADDR[11:0] == AddrMp3);
  assign hit_sd  = (ADDR[11:0] == AddrSd);
  assign hit_ctl = (ADDR[11:0] == AddrCtl);
  assign hit_any = hit_vol | hit_led | hit_mp3 | hit_sd | hit_ctl;

  // Only the low 12 address bits take part in peripheral decode.
  logic unused_addr;
  assign unused_addr = ^ADDR[31:12];

  // ---------------------------------------------------------------------------
  // State declarations
  // ---------------------------------------------------------------------------
  sd_state_e sd_state_q;

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [31:0]        mem_q [FIFO_DEPTH];

  logic fifo_full, fifo_empty, sd_pend;
  logic push, pop, flush;

  assign fifo_full  = (count_q == DepthCnt);
  assign fifo_empty = (count_q == '0);
  assign sd_pend    = (sd_state_q == StPend);

  // ---------------------------------------------------------------------------
  // CPU-facing handshake
  // ---------------------------------------------------------------------------
  assign STALL   = WE & ((hit_mp3 & fifo_full) | (hit_sd & sd_pend));
  assign DMEM_WE = WE & ~hit_any;

  // ---------------------------------------------------------------------------
  // Plain peripheral registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      VOL_REG <= '0;
      LED_REG <= '0;
    end else begin
      if (WE && hit_vol) VOL_REG <= DATA_W;
      if (WE && hit_led) LED_REG <= DATA_W;
    end
  end

  // ---------------------------------------------------------------------------
  // MP3 FIFO
  // ---------------------------------------------------------------------------
  // Push is gated by full alone, so a same-cycle pop never frees a slot early.
  assign push  = WE & hit_mp3 & ~fifo_full;
  assign pop   = MP3_VALID & MP3_READY;
  assign flush = WE & hit_ctl & DATA_W[0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (push && !pop)      count_d = count_q + CntOne;
      else if (pop && !push) count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible while count is non-zero.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= DATA_W;
  end

  assign MP3_DATA  = mem_q[rd_ptr_q];
  assign MP3_VALID = ~fifo_empty;

  // ---------------------------------------------------------------------------
  // SD command FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sd_state_q   <= StIdle;
      SD_CMD       <= '0;
      SD_CMD_VALID <= 1'b0;
    end else begin
      unique case (sd_state_q)
        StIdle: begin
          if (WE && hit_sd) begin
            SD_CMD       <= DATA_W;
            SD_CMD_VALID <= 1'b1;
            sd_state_q   <= StPend;
          end
        end
        StPend: begin
          // SD_CMD keeps the last command after the handshake completes.
          if (SD_CMD_READY) begin
            SD_CMD_VALID <= 1'b0;
            sd_state_q   <= StIdle;
          end
        end
        default: begin
          SD_CMD_VALID <= 1'b0;
          sd_state_q   <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status word
  // ---------------------------------------------------------------------------
`ifdef IFACE_O_STATUS_EN
  logic [7:0] count_ext;
  assign count_ext = {{(7 - FIFO_AW){1'b0}}, count_q};
  assign STATUS    = {16'b0, count_ext, 5'b0, sd_pend, fifo_full, fifo_empty};
`else
  assign STATUS = '0;
`endif

endmodule

// File: tb/tb_interface_o.sv
// Scoreboard bench for interface_o: directed scenarios plus randomized store traffic
// checked against a queue-based reference model.
module tb_interface_o;

  localparam int Depth = 8;

  logic        CLK;
  logic        RST_N;
  logic [31:0] ADDR;
  logic [31:0] DATA_W;
  logic        WE;
  logic        DMEM_WE;
  logic        STALL;
  logic [31:0] VOL_REG;
  logic [31:0] LED_REG;
  logic [31:0] MP3_DATA;
  logic        MP3_VALID;
  logic        MP3_READY;
  logic [31:0] SD_CMD;
  logic        SD_CMD_VALID;
  logic        SD_CMD_READY;
  logic [31:0] STATUS;

  interface_o #(
    .FIFO_DEPTH(8),
    .FIFO_AW   (3)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .ADDR        (ADDR),
    .DATA_W      (DATA_W),
    .WE          (WE),
    .DMEM_WE     (DMEM_WE),
    .STALL       (STALL),
    .VOL_REG     (VOL_REG),
    .LED_REG     (LED_REG),
    .MP3_DATA    (MP3_DATA),
    .MP3_VALID   (MP3_VALID),
    .MP3_READY   (MP3_READY),
    .SD_CMD      (SD_CMD),
    .SD_CMD_VALID(SD_CMD_VALID),
    .SD_CMD_READY(SD_CMD_READY),
    .STATUS      (STATUS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mdl_fifo[$];
  logic        m_pend;
  logic [31:0] m_cmd, m_vol, m_led;

  // Scoreboard queues, drained by the monitor on DUT handshakes
  logic [31:0] exp_mp3[$];
  logic [31:0] exp_sd[$];

  logic [31:0] mon_e;
  logic        st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status();
`ifdef IFACE_O_STATUS_EN
    logic [7:0] c;
    c = 8'(mdl_fifo.size());
    return {16'b0, c, 5'b0, m_pend, mdl_fifo.size() == Depth, mdl_fifo.size() == 0};
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_clear();
    mdl_fifo.delete();
    exp_mp3.delete();
    exp_sd.delete();
    m_pend = 1'b0;
    m_cmd  = '0;
    m_vol  = '0;
    m_led  = '0;
  endtask

  // One store cycle: drive at posedge+1, check at posedge+2, update model after next edge.
  task automatic cycle(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic mrdy, input logic srdy, output logic stalled);
    logic [11:0] a;
    logic        full, hit, exp_stall, push, pop, flush, acc, done;
    WE           = we;
    ADDR         = addr;
    DATA_W       = data;
    MP3_READY    = mrdy;
    SD_CMD_READY = srdy;
    #1;
    a         = addr[11:0];
    full      = (mdl_fifo.size() == Depth);
    hit       = (a == 12'h804) || (a == 12'h80C) || (a == 12'h840) ||
                (a == 12'h844) || (a == 12'h848);
    exp_stall = we && ((a == 12'h840 && full) || (a == 12'h844 && m_pend));
    chk("stall", {31'b0, STALL}, {31'b0, exp_stall});
    chk("dmem_we", {31'b0, DMEM_WE}, {31'b0, we && !hit});
    chk("vol_reg", VOL_REG, m_vol);
    chk("led_reg", LED_REG, m_led);
    chk("mp3_valid", {31'b0, MP3_VALID}, {31'b0, mdl_fifo.size() != 0});
    if (mdl_fifo.size() != 0) chk("mp3_head", MP3_DATA, mdl_fifo[0]);
    chk("sd_valid", {31'b0, SD_CMD_VALID}, {31'b0, m_pend});
    chk("sd_cmd", SD_CMD, m_cmd);
    chk("status", STATUS, exp_status());
    stalled = exp_stall;

    flush = we && a == 12'h848 && data[0];
    pop   = (mdl_fifo.size() != 0) && mrdy;
    push  = we && a == 12'h840 && !full;
    acc   = we && a == 12'h844 && !m_pend;
    done  = m_pend && srdy;

    @(posedge CLK);
    #1;
    if (flush) begin
      mdl_fifo.delete();
      exp_mp3.delete();
    end else begin
      if (pop) void'(mdl_fifo.pop_front());
      if (push) begin
        mdl_fifo.push_back(data);
        exp_mp3.push_back(data);
      end
    end
    if (done) m_pend = 1'b0;
    if (acc) begin
      m_pend = 1'b1;
      m_cmd  = data;
      exp_sd.push_back(data);
    end
    if (we && a == 12'h804) m_vol = data;
    if (we && a == 12'h80C) m_led = data;
  endtask

  // Asynchronous reset between clock edges; outputs must clear before any edge.
  task automatic mid_reset();
    WE           = 1'b0;
    MP3_READY    = 1'b0;
    SD_CMD_READY = 1'b0;
    #1;
    RST_N = 1'b0;
    #1;
    model_clear();
    chk("rst_sd_valid", {31'b0, SD_CMD_VALID}, 32'h0);
    chk("rst_mp3_valid", {31'b0, MP3_VALID}, 32'h0);
    chk("rst_status", STATUS, exp_status());
    @(negedge CLK);
    #2;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare every DUT handshake against the scoreboard queues
  always @(negedge CLK) begin
    if (RST_N) begin
      if (MP3_VALID && MP3_READY) begin
        if (exp_mp3.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mp3_pop: got %h expected no pop", MP3_DATA);
        end else begin
          mon_e = exp_mp3.pop_front();
          chk("mp3_pop", MP3_DATA, mon_e);
        end
      end
      if (SD_CMD_VALID && SD_CMD_READY) begin
        if (exp_sd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sd_handshake: got %h expected no command", SD_CMD);
        end else begin
          mon_e = exp_sd.pop_front();
          chk("sd_handshake", SD_CMD, mon_e);
        end
      end
    end
  end

  initial begin
    logic [31:0] r, addr, data;
    int n;
    WE           = 1'b0;
    ADDR         = '0;
    DATA_W       = '0;
    MP3_READY    = 1'b0;
    SD_CMD_READY = 1'b0;
    RST_N        = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Register store then plain memory store
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, st);
    cycle(1'b1, 32'h0000_0804, 32'h0000_1F1F, 1'b0, 1'b0, st);
    cycle(1'b1, 32'h0000_0123, 32'h0000_00AA, 1'b0, 1'b0, st);
    cycle(1'b1, 32'h0000_080C, 32'h5A5A_0001, 1'b0, 1'b0, st);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, st);

    // Fill FIFO, stall on the ninth push, then retry while the consumer drains
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h0000_0840, i, 1'b0, 1'b0, st);
    cycle(1'b1, 32'h0000_0840, 32'h99, 1'b0, 1'b0, st);
    st = 1'b1;
    n  = 0;
    while (st && n < 6) begin
      cycle(1'b1, 32'h0000_0840, 32'h99, 1'b1, 1'b0, st);
      n++;
    end
    repeat (10) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, st);

    // Simultaneous push and pop with three words held
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_0840, 32'h100 + i, 1'b0, 1'b0, st);
    cycle(1'b1, 32'h0000_0840, 32'h55, 1'b1, 1'b0, st);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, st);
    repeat (5) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, st);

    // SD command held while a second command stalls
    cycle(1'b1, 32'h0000_0844, 32'hCAFE_0001, 1'b0, 1'b0, st);
    repeat (4) cycle(1'b1, 32'h0000_0844, 32'h2, 1'b0, 1'b0, st);
    cycle(1'b1, 32'h0000_0844, 32'h2, 1'b0, 1'b1, st);
    cycle(1'b1, 32'h0000_0844, 32'h2, 1'b0, 1'b0, st);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, st);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, st);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, st);

    // Flush with a concurrent pop
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_0840, 32'h200 + i, 1'b0, 1'b0, st);
    cycle(1'b1, 32'h0000_0848, 32'h1, 1'b1, 1'b0, st);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, st);

    // Reset mid-operation: SD pending and FIFO non-empty
    cycle(1'b1, 32'h0000_0844, 32'h0000_0077, 1'b0, 1'b0, st);
    cycle(1'b1, 32'h0000_0840, 32'h0000_0301, 1'b0, 1'b0, st);
    cycle(1'b1, 32'h0000_0840, 32'h0000_0302, 1'b0, 1'b0, st);
    mid_reset();
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, st);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      case ($urandom_range(0, 7))
        0:       addr = {r[31:12], 12'h804};
        1:       addr = {r[31:12], 12'h80C};
        2, 3:    addr = {r[31:12], 12'h840};
        4:       addr = {r[31:12], 12'h844};
        5:       addr = {r[31:12], 12'h848};
        6:       addr = {r[31:12], 12'h810 + 12'($urandom_range(0, 7) * 4)};
        default: addr = r & 32'hFFFF_F7FF;
      endcase
      data = $urandom;
      if (addr[11:0] == 12'h848 && $urandom_range(0, 3) != 0) data[0] = 1'b0;
      cycle($urandom_range(0, 9) < 7, addr, data, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, st);
    end

    // Drain everything still outstanding, bounded
    n = 0;
    while ((exp_mp3.size() != 0 || exp_sd.size() != 0 || m_pend) && n < 40) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, st);
      n++;
    end
    chk("drain_mp3_left", exp_mp3.size(), 32'h0);
    chk("drain_sd_left", exp_sd.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
